// File: rtl/redundant_replicator_pkg.sv
// Shared types and constants for the redundant instruction replicator.
// States and the output struct live here so the instruction queue can reuse them.
package redundant_replicator_pkg;

  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 64};

  localparam int unsigned PAIR_ID_WIDTH = 3;
  localparam int unsigned MAX_VLEN      = 64;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PRIMARY = 2'd1;
  localparam logic [1:0] ST_SHADOW  = 2'd2;

  typedef struct packed {
    logic [31:0]              instr;
    logic [MAX_VLEN-1:0]      pc;
    logic                     shadow;
    logic                     dup;
    logic [PAIR_ID_WIDTH-1:0] pair_id;
  } replicator_out_t;

endpackage

// File: rtl/redundant_replicator.sv
// One-entry skid stage that re-issues eligible instructions as a primary/shadow pair.
// Handshakes: a transfer happens on any cycle where valid and ready are both high.
module redundant_replicator
  import redundant_replicator_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned PairIdWidth = PAIR_ID_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    en_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [31:0]             instr_i,
  input  logic [CVA6Cfg.VLEN-1:0] pc_i,
  input  logic                    redundant_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             instr_o,
  output logic [CVA6Cfg.VLEN-1:0] pc_o,
  output logic                    shadow_o,
  output logic                    dup_o,
  output logic [PairIdWidth-1:0]  pair_id_o
);

  localparam int unsigned VLEN = CVA6Cfg.VLEN;

  logic [1:0]             state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [VLEN-1:0]        pc_q, pc_d;
  logic                   dup_q, dup_d;
  logic [PairIdWidth-1:0] pair_q, pair_d;
  logic                   dn_xfer;
  logic                   capture;

  // ready_o must never look at valid_i, so it is built from state, dup and ready_i only.
  always_comb begin
    ready_o = 1'b1;
    case (state_q)
      ST_EMPTY:   ready_o = 1'b1;
      ST_PRIMARY: ready_o = ready_i & ~dup_q;
      ST_SHADOW:  ready_o = ready_i;
      default:    ready_o = 1'b1;
    endcase
  end

  assign valid_o = (state_q == ST_PRIMARY) || (state_q == ST_SHADOW);
  assign dn_xfer = valid_o & ready_i;
  assign capture = valid_i & ready_o & ~flush_i;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    dup_d   = dup_q;
    pair_d  = pair_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      if (capture) begin
        instr_d = instr_i;
        pc_d    = pc_i;
        dup_d   = redundant_i & en_i;
        state_d = ST_PRIMARY;
      end else if (dn_xfer) begin
        state_d = (state_q == ST_PRIMARY && dup_q) ? ST_SHADOW : ST_EMPTY;
      end
      // The pair tag advances only once the shadow copy has actually left.
      if (dn_xfer && state_q == ST_SHADOW) begin
        pair_d = pair_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      dup_q   <= 1'b0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      dup_q   <= dup_d;
      pair_q  <= pair_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign shadow_o  = (state_q == ST_SHADOW);
  assign dup_o     = dup_q;
  assign pair_id_o = pair_q;

endmodule

// File: doc/redundant_replicator.md
REDUNDANT_REPLICATOR -- requirements
Module: redundant_replicator

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty: core configuration; supplies VLEN.
REQ-002 Parameter PairIdWidth, default 3: width of the redundant-pair tag.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 flush_i  input  1  frontend flush; drops the held entry.
REQ-006 en_i  input  1  redundancy enable; when 0, no instruction is duplicated.
REQ-007 valid_i  input  1  upstream instruction valid.
REQ-008 ready_o  output  1  this block can accept the upstream instruction this cycle.
REQ-009 instr_i  input  32  instruction word, already realigned.
REQ-010 pc_i  input  VLEN  instruction address.
REQ-011 redundant_i  input  1  predecode flag: instruction is eligible for redundant issue.
REQ-012 valid_o  output  1  downstream entry valid.
REQ-013 ready_i  input  1  downstream (instruction queue) ready.
REQ-014 instr_o  output  32  held instruction word.
REQ-015 pc_o  output  VLEN  held address.
REQ-016 shadow_o  output  1  0 = primary copy, 1 = shadow copy.
REQ-017 dup_o  output  1  entry belongs to a redundant pair.
REQ-018 pair_id_o  output  PairIdWidth  tag shared by both copies of a pair.

Function
REQ-019 Handshakes are valid/ready: a transfer occurs on a cycle where valid and ready are both high; valid_o, once high, stays high with stable payload until the transfer or a flush.
REQ-020 FSM states EMPTY, PRIMARY, SHADOW; a one-entry register holds instr, pc and the dup flag.
REQ-021 EMPTY: valid_o=0, ready_o=1; on an upstream transfer, the entry is captured with dup = redundant_i & en_i and the FSM goes to PRIMARY.
REQ-022 PRIMARY: valid_o=1, shadow_o=0.
REQ-023 PRIMARY with downstream transfer and dup=1: go to SHADOW with the same payload; ready_o=0 in this cycle.
REQ-024 PRIMARY with downstream transfer and dup=0: ready_o=1; a simultaneous upstream transfer reloads the entry and stays in PRIMARY; otherwise go to EMPTY.
REQ-025 PRIMARY without downstream transfer: ready_o=0 and the payload is held.
REQ-026 SHADOW: valid_o=1, shadow_o=1, dup_o=1.
REQ-027 SHADOW with downstream transfer: ready_o=1; pair_id increments modulo 2^PairIdWidth; an upstream transfer in the same cycle reloads into PRIMARY, otherwise go to EMPTY.
REQ-028 Throughput: one instruction per cycle for non-redundant traffic; two cycles per redundant instruction.
REQ-029 Latency: input to valid_o is exactly one cycle; there is no combinational path from valid_i to valid_o.
REQ-030 ready_o depends only on state, dup and ready_i, never on valid_i.
REQ-031 pair_id_o is valid in both PRIMARY and SHADOW; it increments only on SHADOW completion and wraps from all-ones to 0.
REQ-032 flush_i forces EMPTY next cycle regardless of state and ignores a same-cycle upstream transfer; pair_id is not reset by a flush.
REQ-033 A flush in SHADOW discards the shadow copy and pair_id does not increment.
REQ-034 en_i is sampled only at capture; a change mid-pair does not cancel a pending shadow.

Reset
REQ-035 While rst_i is high: state=EMPTY, entry cleared, pair_id=0, valid_o=0, ready_o=1, instr_o=0, pc_o=0, shadow_o=0, dup_o=0, pair_id_o=0.
REQ-036 Reset asserted mid-pair aborts the pair with no shadow output.

Structure
REQ-037 The state enum (EMPTY, PRIMARY, SHADOW) and the pair-id width constant reside in ariane_pkg; an output struct {instr, pc, shadow, dup, pair_id} is defined there for instruction-queue reuse.
REQ-038 No sub-module; this is a single flat module instantiated in the frontend after the predecoder.

Verification
REQ-039 Reset, then valid_i=1 with instr=0x00A00513 (addi), redundant_i=1, en_i=1, ready_i=1 -> two valid_o beats: shadow_o 0 then 1, pair_id_o=0 on both, then pair_id=1.
REQ-040 Back-to-back 0x0000006F (jal), redundant_i=0, ready_i=1 -> one output per cycle, dup_o=0, ready_o held high.
REQ-041 Redundant instruction with ready_i=0 for 3 cycles -> payload stable, ready_o=0; after release, primary then shadow.
REQ-042 Flush asserted in SHADOW -> valid_o=0 next cycle, pair_id unchanged.
REQ-043 Nine consecutive redundant pairs with PairIdWidth=3 -> pair_id_o sequence 0..7, 0.
REQ-044 en_i=0 with redundant_i=1 -> single beat with dup_o=0.
